// File: rtl/serial_deframer.sv
// serial_deframer: hunts for a sync word in a serial bit stream (MSB first), then assembles
// NWORDS words of WIDTH bits each and presents them on a one-entry valid/ready buffer.
// Optional feature macro: DEFRAMER_PARITY_EN (each data word followed by an even-parity bit).
module serial_deframer #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] SYNC   = 8'hA5,
  parameter int unsigned      NWORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             drdy,
  output logic             locked,
  output logic             ovf,
  output logic             par_err
);

`ifdef DEFRAMER_PARITY_EN
  localparam int unsigned BitsPerWord = WIDTH + 1;
`else
  localparam int unsigned BitsPerWord = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(BitsPerWord + 1);
  localparam int unsigned WcW  = $clog2(NWORDS + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(BitsPerWord - 1);
  localparam logic [CntW-1:0] DataBits = CntW'(WIDTH);
  localparam logic [WcW-1:0]  LastWord = WcW'(NWORDS - 1);

  typedef enum logic [0:0] {StHunt, StCollect} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hunt_q;
  logic [WIDTH-1:0] asm_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [WcW-1:0]   word_cnt_q;

  logic [WIDTH-1:0] hunt_nxt;
  logic [WIDTH-1:0] asm_nxt;
  logic [WIDTH-1:0] word_data;
  logic             word_done;
  logic             last_word;
  logic             xfer;
  logic             par_bad;

`ifdef DEFRAMER_PARITY_EN
  logic par_q;

  // Running XOR of the current word's bits, restarted on the first bit of each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (en && state_q == StCollect) begin
      par_q <= (bit_cnt_q == '0) ? si : (par_q ^ si);
    end
  end
`endif

  // Shift candidates, word-completion decode and handshake terms.
  always_comb begin
    hunt_nxt  = {hunt_q[WIDTH-2:0], si};
    asm_nxt   = {asm_q[WIDTH-2:0], si};
    word_done = en && (state_q == StCollect) && (bit_cnt_q == LastBit);
    last_word = (word_cnt_q == LastWord);
    xfer      = dvalid && drdy;
`ifdef DEFRAMER_PARITY_EN
    // Last bit of the word is the parity bit, so the data is already in asm_q.
    word_data = asm_q;
    par_bad   = par_q ^ si;
`else
    word_data = asm_nxt;
    par_bad   = 1'b0;
`endif
  end

  // Hunt/collect FSM with registered outputs and the one-entry output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      hunt_q     <= '0;
      asm_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      dout       <= '0;
      dvalid     <= 1'b0;
      locked     <= 1'b0;
      ovf        <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      if (en) begin
        unique case (state_q)
          StHunt: begin
            hunt_q <= hunt_nxt;
            if (hunt_nxt == SYNC) begin
              state_q    <= StCollect;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              locked     <= 1'b1;
            end
          end
          StCollect: begin
            // The parity bit, when present, is not shifted into the data word.
            if (bit_cnt_q < DataBits) begin
              asm_q <= asm_nxt;
            end
            if (word_done) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_q + WcW'(1);
              if (last_word) begin
                state_q    <= StHunt;
                hunt_q     <= '0;
                word_cnt_q <= '0;
                locked     <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          default: state_q <= StHunt;
        endcase
      end

      // A completed word is dropped (and flagged) only if the buffer is full and not draining.
      if (word_done) begin
        if (!dvalid || drdy) begin
          dout   <= word_data;
          dvalid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
        if (par_bad) begin
          par_err <= 1'b1;
        end
      end else if (xfer) begin
        dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer (NWORDS=2): directed scenarios followed by random
// framed/noisy streams with random en/drdy, all compared every cycle against a bit-level model.
module tb_serial_deframer;

  localparam int W  = 8;
  localparam int NW = 2;
  localparam logic [7:0] SYNCW = 8'hA5;
`ifdef DEFRAMER_PARITY_EN
  localparam int BPW = W + 1;
`else
  localparam int BPW = W;
`endif

  logic       clk;
  logic       rst_n;
  logic       si;
  logic       en;
  logic       drdy;
  logic [7:0] dout;
  logic       dvalid;
  logic       locked;
  logic       ovf;
  logic       par_err;

  int total;
  int bad;

  // Reference model state
  bit       m_locked;
  int       m_hunt;
  int       m_nbits;
  int       m_words;
  int       m_cur;
  int       m_ones;
  bit [7:0] m_dout;
  bit       m_dvalid;
  bit       m_ovf;
  bit       m_perr;

  serial_deframer #(
    .WIDTH (W),
    .SYNC  (SYNCW),
    .NWORDS(NW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .si     (si),
    .en     (en),
    .dout   (dout),
    .dvalid (dvalid),
    .drdy   (drdy),
    .locked (locked),
    .ovf    (ovf),
    .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_hunt = 0; m_nbits = 0; m_words = 0; m_cur = 0; m_ones = 0;
    m_dout = '0; m_dvalid = 0; m_ovf = 0; m_perr = 0;
  endtask

  // One clock edge of the behavioural model, from the frame rules directly.
  task automatic model_edge(input bit b, input bit e, input bit r);
    bit done;
    bit badpar;
    int word;
    bit xfer;
    done = 0; badpar = 0; word = 0;
    xfer = m_dvalid && r;
    if (e) begin
      if (!m_locked) begin
        m_hunt = ((m_hunt << 1) | int'(b)) & 'hFF;
        if (m_hunt == int'(SYNCW)) begin
          m_locked = 1; m_nbits = 0; m_words = 0; m_cur = 0; m_ones = 0;
        end
      end else begin
        if (m_nbits < W) m_cur = ((m_cur << 1) | int'(b)) & 'hFF;
        m_ones += int'(b);
        m_nbits++;
        if (m_nbits == BPW) begin
          done   = 1;
          word   = m_cur;
          badpar = (BPW != W) && (m_ones % 2 == 1);
          m_nbits = 0; m_cur = 0; m_ones = 0;
          m_words++;
          if (m_words == NW) begin
            m_locked = 0; m_hunt = 0;
          end
        end
      end
    end
    if (done) begin
      if (!m_dvalid || r) begin
        m_dout   = word[7:0];
        m_dvalid = 1;
      end else begin
        m_ovf = 1;
      end
      if (badpar) m_perr = 1;
    end else if (xfer) begin
      m_dvalid = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("dout", 32'(dout), 32'(m_dout));
    check_eq("dvalid", 32'(dvalid), 32'(m_dvalid));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("par_err", 32'(par_err), 32'(m_perr));
  endtask

  // Drive one cycle; drdy is whatever the caller left on the port.
  task automatic step(input bit b, input bit e);
    si = b;
    en = e;
    @(posedge clk);
    model_edge(b, e, drdy);
    #1;
    compare_all();
  endtask

  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask

  // Data word plus its parity bit when the parity build is selected.
  task automatic send_data(input logic [7:0] v);
    send_bits(v);
    if (BPW != W) step(^v, 1'b1);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_dvalid", 32'(dvalid), 32'h0);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    check_eq("rst_par_err", 32'(par_err), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit q[$];

  initial begin
    total = 0; bad = 0;
    si = 0; en = 0; drdy = 1; rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Basic frame
    drdy = 1;
    send_bits(SYNCW);
    check_eq("basic_lock", 32'(locked), 32'h1);
    send_data(8'h3C);
    check_eq("basic_w0", 32'(dout), 32'h3C);
    check_eq("basic_v0", 32'(dvalid), 32'h1);
    send_data(8'h81);
    check_eq("basic_w1", 32'(dout), 32'h81);
    check_eq("basic_unlock", 32'(locked), 32'h0);
    check_eq("basic_ovf", 32'(ovf), 32'h0);

    // False / overlapping sync: AA then 1010 0101
    apply_reset();
    send_bits(8'hAA);
    for (int i = 7; i >= 1; i--) begin
      step(SYNCW[i], 1'b1);
      check_eq("false_nolock", 32'(locked), 32'h0);
    end
    step(SYNCW[0], 1'b1);
    check_eq("false_lock", 32'(locked), 32'h1);
    send_data(8'h5A);
    send_data(8'hC3);

    // Overrun
    apply_reset();
    drdy = 0;
    send_bits(SYNCW);
    send_data(8'h11);
    send_data(8'h22);
    check_eq("ovr_dout", 32'(dout), 32'h11);
    check_eq("ovr_dvalid", 32'(dvalid), 32'h1);
    check_eq("ovr_ovf", 32'(ovf), 32'h1);
    drdy = 1;
    step(1'b0, 1'b0);
    drdy = 0;
    check_eq("ovr_drain", 32'(dvalid), 32'h0);

    // en gaps
    apply_reset();
    drdy = 1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] v;
      v = (k == 0) ? SYNCW : ((k == 1) ? 8'h3C : 8'h81);
      for (int i = 7; i >= 0; i--) begin
        step(v[i], 1'b1);
        if (k > 0 && i == 0 && BPW == W) check_eq("gap_word", 32'(dout), 32'(v));
        step(~v[i], 1'b0);
      end
      if (k > 0 && BPW != W) begin
        step(^v, 1'b1);
        check_eq("gap_word", 32'(dout), 32'(v));
      end
    end

    // Reset mid-word
    apply_reset();
    send_bits(SYNCW);
    for (int i = 0; i < 4; i++) step(i[0], 1'b1);
    apply_reset();
    send_bits(SYNCW);
    send_data(8'h55);
    check_eq("rst_w0", 32'(dout), 32'h55);
    send_data(8'h66);
    check_eq("rst_w1", 32'(dout), 32'h66);

`ifdef DEFRAMER_PARITY_EN
    // Parity: 0F+0 is clean, F0+1 is a mismatch
    apply_reset();
    send_bits(SYNCW);
    send_bits(8'h0F);
    step(1'b0, 1'b1);
    check_eq("par_w0", 32'(dout), 32'h0F);
    check_eq("par_ok", 32'(par_err), 32'h0);
    send_bits(8'hF0);
    step(1'b1, 1'b1);
    check_eq("par_w1", 32'(dout), 32'hF0);
    check_eq("par_bad", 32'(par_err), 32'h1);
`endif

    // Random frames with noise, random en and drdy
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(0, 1)));
      for (int i = 7; i >= 0; i--) q.push_back(SYNCW[i]);
      for (int i = 0; i < NW * BPW; i++) q.push_back(bit'($urandom_range(0, 1)));
    end
    while (q.size() > 0) begin
      bit e;
      e = ($urandom_range(0, 3) != 0);
      drdy = bit'($urandom_range(0, 1));
      if (e) step(q.pop_front(), 1'b1);
      else step(bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
